// File: rtl/mul_seq.sv
// Iterative shift-add 64-bit RV64M multiplier: one partial-product step per cycle
// through a single shared ripple adder, with optional two's-complement correction.

module add (
   input  logic [63:0] in_a,
   input  logic [63:0] in_b,
   input  logic        in_c,
   input  logic        alu_32,
   output logic [63:0] out_s,
   output logic        out_c
);

   logic [64:0] w_sum;

   assign w_sum = {1'b0, in_a} + {1'b0, in_b} + {64'd0, in_c};
   assign out_s = alu_32 ? {{32{w_sum[31]}}, w_sum[31:0]} : w_sum[63:0];
   assign out_c = w_sum[64];

endmodule

module mul_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        mul_valid,
   output logic        mul_ready,
   input  logic [1:0]  mul_op,
   input  logic        mul_32,
   input  logic [63:0] src1,
   input  logic [63:0] src2,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] result
);

   typedef enum logic [2:0] {
      S_IDLE, S_PREP, S_ITER, S_NEGL, S_NEGH, S_DONE
   } state_t;

   state_t      r_state;
   logic [63:0] r_hi;
   logic [63:0] r_lo;
   logic [63:0] r_mcand;
   logic [63:0] r_mplier;
   logic [6:0]  r_cnt;
   logic [1:0]  r_op;
   logic        r_w32;
   logic        r_neg;
   logic        r_carry;
   logic        r_outValid;
   logic [63:0] r_result;

   logic [63:0] w_addA;
   logic [63:0] w_addB;
   logic        w_addC;
   logic [63:0] w_sum;
   logic        w_carry;
   logic        w_sign1;
   logic        w_sign2;
   logic [63:0] w_mag1;
   logic [63:0] w_mag2;
   logic [63:0] w_iterHi;
   logic [63:0] w_iterLo;

   add u_add (
      .in_a   (w_addA),
      .in_b   (w_addB),
      .in_c   (w_addC),
      .alu_32 (1'b0),
      .out_s  (w_sum),
      .out_c  (w_carry)
   );

   // After 32 steps the MULW product sits in the upper half of lo.
   function automatic logic [63:0] selResult(input logic [63:0] hi, input logic [63:0] lo,
                                             input logic [1:0] op, input logic w32);
      if (w32)
         return {{32{lo[63]}}, lo[63:32]};
      else if (op == 2'b00)
         return lo;
      else
         return hi;
   endfunction

   assign w_sign1 = !r_w32 && (r_op == 2'b01 || r_op == 2'b10) && r_mcand[63];
   assign w_sign2 = !r_w32 && (r_op == 2'b01) && r_mplier[63];
   assign w_mag1  = r_w32 ? {32'd0, r_mcand[31:0]}
                          : (w_sign1 ? (~r_mcand + 64'd1) : r_mcand);
   assign w_mag2  = r_w32 ? {32'd0, r_mplier[31:0]}
                          : (w_sign2 ? (~r_mplier + 64'd1) : r_mplier);

   assign w_iterHi = {w_carry, w_sum[63:1]};
   assign w_iterLo = {w_sum[0], r_lo[63:1]};

   always_comb begin
      w_addA = 64'd0;
      w_addB = 64'd0;
      w_addC = 1'b0;
      case (r_state)
         S_ITER: begin
            w_addA = r_hi;
            w_addB = r_mplier[0] ? r_mcand : 64'd0;
         end
         S_NEGL: begin
            w_addA = ~r_lo;
            w_addC = 1'b1;
         end
         S_NEGH: begin
            w_addA = ~r_hi;
            w_addC = r_carry;
         end
         default: ;
      endcase
   end

   // Flush outranks every handshake and wipes the accumulator.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_hi       <= 64'd0;
         r_lo       <= 64'd0;
         r_mcand    <= 64'd0;
         r_mplier   <= 64'd0;
         r_cnt      <= 7'd0;
         r_op       <= 2'd0;
         r_w32      <= 1'b0;
         r_neg      <= 1'b0;
         r_carry    <= 1'b0;
         r_outValid <= 1'b0;
         r_result   <= 64'd0;
      end else if (flush) begin
         r_state    <= S_IDLE;
         r_hi       <= 64'd0;
         r_lo       <= 64'd0;
         r_cnt      <= 7'd0;
         r_neg      <= 1'b0;
         r_carry    <= 1'b0;
         r_outValid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (mul_valid) begin
                  r_mcand  <= src1;
                  r_mplier <= src2;
                  r_op     <= mul_op;
                  r_w32    <= mul_32;
                  r_state  <= S_PREP;
               end
            end
            S_PREP: begin
               r_mcand  <= w_mag1;
               r_mplier <= w_mag2;
               r_neg    <= w_sign1 ^ w_sign2;
               r_hi     <= 64'd0;
               r_lo     <= 64'd0;
               r_cnt    <= r_w32 ? 7'd32 : 7'd64;
               r_state  <= S_ITER;
            end
            S_ITER: begin
               r_hi     <= w_iterHi;
               r_lo     <= w_iterLo;
               r_mplier <= {1'b0, r_mplier[63:1]};
               r_cnt    <= r_cnt - 7'd1;
               if (r_cnt == 7'd1) begin
                  if (r_neg) begin
                     r_state <= S_NEGL;
                  end else begin
                     r_state    <= S_DONE;
                     r_outValid <= 1'b1;
                     r_result   <= selResult(w_iterHi, w_iterLo, r_op, r_w32);
                  end
               end
            end
            S_NEGL: begin
               r_lo    <= w_sum;
               r_carry <= w_carry;
               r_state <= S_NEGH;
            end
            S_NEGH: begin
               r_hi       <= w_sum;
               r_state    <= S_DONE;
               r_outValid <= 1'b1;
               r_result   <= selResult(w_sum, r_lo, r_op, r_w32);
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state    <= S_IDLE;
                  r_outValid <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign mul_ready = (r_state == S_IDLE) && !rst;
   assign out_valid = r_outValid;
   assign result    = r_result;

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: stimulus pushes reference results, a negedge
// monitor pops and compares value and latency whenever a result is presented.

module tb_mul_seq;

   logic        clk;
   logic        rst;
   logic        mul_valid;
   logic        mul_ready;
   logic [1:0]  mul_op;
   logic        mul_32;
   logic [63:0] src1;
   logic [63:0] src2;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result;

   typedef struct {
      logic [63:0] res;
      int          lat;
      int          acc;
   } expItem_t;

   expItem_t expQ[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int holdReq = 0;

   mul_seq dut (
      .clk       (clk),
      .rst       (rst),
      .mul_valid (mul_valid),
      .mul_ready (mul_ready),
      .mul_op    (mul_op),
      .mul_32    (mul_32),
      .src1      (src1),
      .src2      (src2),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference model: sign-extend to 128 bits per op and multiply directly.
   function automatic logic [63:0] refMul(input logic [1:0] op, input logic w32,
                                          input logic [63:0] a, input logic [63:0] b);
      logic [127:0] ea;
      logic [127:0] eb;
      logic [127:0] p;
      logic [63:0]  p32;
      if (w32) begin
         p32 = {32'd0, a[31:0]} * {32'd0, b[31:0]};
         return {{32{p32[31]}}, p32[31:0]};
      end
      ea = (op == 2'b01 || op == 2'b10) ? {{64{a[63]}}, a} : {64'd0, a};
      eb = (op == 2'b01) ? {{64{b[63]}}, b} : {64'd0, b};
      p  = ea * eb;
      return (op == 2'b00) ? p[63:0] : p[127:64];
   endfunction

   function automatic int refLat(input logic [1:0] op, input logic w32,
                                 input logic [63:0] a, input logic [63:0] b);
      logic neg;
      if (w32) return 34;
      neg = (((op == 2'b01) || (op == 2'b10)) && a[63]) ^ ((op == 2'b01) && b[63]);
      return neg ? 68 : 66;
   endfunction

   function automatic logic [63:0] pickOperand();
      case ($urandom_range(0, 4))
         0: return {$urandom(), $urandom()};
         1: return 64'($urandom_range(0, 100));
         2: return 64'h8000_0000_0000_0000;
         3: return 64'hFFFF_FFFF_FFFF_FFFF;
         default: return -64'($urandom_range(1, 50));
      endcase
   endfunction

   task automatic issueRaw(input logic [1:0] op, input logic w32,
                           input logic [63:0] a, input logic [63:0] b, output int accCyc);
      int t = 0;
      @(negedge clk);
      while (!mul_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (!mul_ready) begin
         checks++;
         errors++;
         $display("[TB] FAIL readyTimeout actual=0 required=1");
      end
      mul_valid = 1'b1;
      mul_op    = op;
      mul_32    = w32;
      src1      = a;
      src2      = b;
      @(posedge clk);
      #1;
      mul_valid = 1'b0;
      accCyc    = cyc;
   endtask

   task automatic applyStimulus(input logic [1:0] op, input logic w32,
                                input logic [63:0] a, input logic [63:0] b, input int hold);
      int acc;
      expItem_t e;
      holdReq = hold;
      issueRaw(op, w32, a, b, acc);
      e.res = refMul(op, w32, a, b);
      e.lat = refLat(op, w32, a, b);
      e.acc = acc;
      expQ.push_back(e);
   endtask

   task automatic waitDrain();
      int t = 0;
      while ((expQ.size() != 0 || out_valid) && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (expQ.size() != 0 || out_valid) begin
         checks++;
         errors++;
         $display("[TB] FAIL drainTimeout actual=%0d required=0", expQ.size());
         expQ.delete();
      end
   endtask

   // Monitor: compare on the first valid cycle, then require the result to hold.
   logic        inValid = 1'b0;
   logic [63:0] heldResult;
   int          holdLeft;
   expItem_t    cur;

   initial out_ready = 1'b0;

   always @(negedge clk) begin
      if (out_valid) begin
         if (!inValid) begin
            inValid    = 1'b1;
            heldResult = result;
            holdLeft   = holdReq;
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpectedResult actual=%h required=none", result);
            end else begin
               cur = expQ.pop_front();
               checkOutput("result", result, cur.res);
               checkOutput("latency", 64'(cyc - cur.acc + 1), 64'(cur.lat));
            end
         end else begin
            checkOutput("resultHeld", result, heldResult);
         end
         if (holdLeft > 0) begin
            out_ready = 1'b0;
            holdLeft--;
         end else begin
            out_ready = 1'b1;
         end
      end else begin
         inValid   = 1'b0;
         out_ready = 1'b0;
      end
   end

   initial begin
      int acc;
      logic sawValid;
      rst       = 1'b1;
      mul_valid = 1'b0;
      mul_op    = 2'b00;
      mul_32    = 1'b0;
      src1      = 64'd0;
      src2      = 64'd0;
      flush     = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("resetReady", 64'(mul_ready), 64'd0);
      checkOutput("resetValid", 64'(out_valid), 64'd0);
      checkOutput("resetResult", result, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("readyAfterReset", 64'(mul_ready), 64'd1);

      applyStimulus(2'b00, 1'b0, 64'd3, 64'd5, 10);
      waitDrain();
      applyStimulus(2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      waitDrain();
      applyStimulus(2'b01, 1'b0, -64'd2, 64'd3, 1);
      waitDrain();
      applyStimulus(2'b10, 1'b0, -64'd1, 64'd2, 0);
      waitDrain();
      applyStimulus(2'b01, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2);
      waitDrain();
      applyStimulus(2'b11, 1'b1, 64'hFFFF_FFFF_0000_FFFF, 64'h0000_0000_0001_0000, 0);
      waitDrain();

      // Flush sampled on the edge ending cycle 20 of an operation.
      issueRaw(2'b01, 1'b0, -64'd9, 64'd11, acc);
      repeat (20) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checkOutput("flushReady", 64'(mul_ready), 64'd1);
      checkOutput("flushValid", 64'(out_valid), 64'd0);
      sawValid = 1'b0;
      repeat (80) begin
         @(negedge clk);
         if (out_valid) sawValid = 1'b1;
      end
      checkOutput("flushNoResult", 64'(sawValid), 64'd0);
      applyStimulus(2'b00, 1'b0, 64'd7, 64'd6, 0);
      waitDrain();

      // Request arriving together with flush in IDLE is dropped.
      @(negedge clk);
      mul_valid = 1'b1;
      mul_op    = 2'b00;
      src1      = 64'd4;
      src2      = 64'd4;
      flush     = 1'b1;
      @(negedge clk);
      mul_valid = 1'b0;
      flush     = 1'b0;
      checkOutput("flushDropReady", 64'(mul_ready), 64'd1);
      sawValid = 1'b0;
      repeat (80) begin
         @(negedge clk);
         if (out_valid) sawValid = 1'b1;
      end
      checkOutput("flushDropNoResult", 64'(sawValid), 64'd0);

      // Reset pulsed in the middle of the iteration phase.
      issueRaw(2'b11, 1'b0, 64'd123, 64'd456, acc);
      repeat (30) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midResetValid", 64'(out_valid), 64'd0);
      checkOutput("midResetResult", result, 64'd0);
      checkOutput("midResetReady", 64'(mul_ready), 64'd0);
      rst = 1'b0;
      applyStimulus(2'b01, 1'b0, -64'd5, 64'd7, 0);
      waitDrain();

      for (int i = 0; i < 40; i++) begin
         applyStimulus(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                       pickOperand(), pickOperand(), $urandom_range(0, 3));
         waitDrain();
      end

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
